// File: rtl/cmd_byte_bridge_if.sv
// rtl/cmd_byte_bridge_if.sv - request/response byte streams and host bus for cmd_byte_bridge
// master: bridge side; slave: byte source/sink and host (cmd_master) side.
interface cmd_byte_bridge_if #(
  parameter int HOST_ADDR_BITS = 32,
  parameter int HOST_DATA_BITS = 32
);
  logic [7:0]                i_rx_byte;
  logic                      i_rx_valid;
  logic                      o_rx_ready;
  logic [7:0]                o_tx_byte;
  logic                      o_tx_valid;
  logic                      i_tx_ready;
  logic                      o_host_sel;
  logic                      o_host_rd_wr_n;
  logic [HOST_ADDR_BITS-1:0] o_host_byte_addr;
  logic [HOST_DATA_BITS-1:0] o_host_wdata;
  logic                      i_host_ack;
  logic [HOST_DATA_BITS-1:0] i_host_rdata;

  modport master (
    input  i_rx_byte, i_rx_valid, i_tx_ready, i_host_ack, i_host_rdata,
    output o_rx_ready, o_tx_byte, o_tx_valid, o_host_sel, o_host_rd_wr_n,
           o_host_byte_addr, o_host_wdata
  );

  modport slave (
    output i_rx_byte, i_rx_valid, i_tx_ready, i_host_ack, i_host_rdata,
    input  o_rx_ready, o_tx_byte, o_tx_valid, o_host_sel, o_host_rd_wr_n,
           o_host_byte_addr, o_host_wdata
  );
endinterface

// File: rtl/cmd_byte_bridge.sv
// rtl/cmd_byte_bridge.sv - byte-stream request parser driving one host read/write per packet
// Optional CMD_BYTE_BRIDGE_CKSUM_EN adds XOR checksum bytes to requests and responses.
module cmd_byte_bridge #(
  parameter int HOST_ADDR_BITS     = 32,
  parameter int HOST_DATA_BITS     = 32,
  parameter int ACK_TIMEOUT_CYCLES = 1024
) (
  input logic              i_sysclk,
  input logic              i_arst_n,
  cmd_byte_bridge_if.master b
);
  localparam int NA = HOST_ADDR_BITS / 8;
  localparam int ND = HOST_DATA_BITS / 8;
  localparam int CW = $clog2(((NA > ND) ? NA : ND) + 1);
  localparam int TW = $clog2(ACK_TIMEOUT_CYCLES);
`ifdef CMD_BYTE_BRIDGE_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int RN = ND + 1 + CK;
  localparam int RW = 8 * RN;
  localparam int LW = $clog2(RN + 1);

  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, BUS, RESP
`ifdef CMD_BYTE_BRIDGE_CKSUM_EN
    , CKSUM
`endif
  } state_t;

`ifdef CMD_BYTE_BRIDGE_CKSUM_EN
  localparam state_t REQ_DONE = CKSUM;
`else
  localparam state_t REQ_DONE = BUS;
`endif

  state_t                    state, state_nxt;
  logic [CW-1:0]             cnt;
  logic [TW-1:0]             tmo;
  logic [HOST_ADDR_BITS-1:0] addr_q;
  logic [HOST_DATA_BITS-1:0] wdata_q;
  logic                      rd_q;
  logic                      run;
  logic [7:0]                rx_x;
  logic [RW-1:0]             sr;
  logic [LW-1:0]             left;

  logic          rx_fire, tx_fire, last_addr, last_data;
  logic          load_ack, load_nak;
  logic [7:0]    rd_x;
  logic [RW-1:0] ack_sr, nak_sr;
  logic [LW-1:0] ack_len, nak_len;

  assign rx_fire   = b.i_rx_valid && b.o_rx_ready;
  assign tx_fire   = b.o_tx_valid && b.i_tx_ready;
  assign last_addr = (cnt == CW'(NA - 1));
  assign last_data = (cnt == CW'(ND - 1));

  always_comb begin
    state_nxt = state;
    load_ack  = 1'b0;
    load_nak  = 1'b0;
    case (state)
      IDLE: if (rx_fire) begin
        if (b.i_rx_byte == OP_RD || b.i_rx_byte == OP_WR) begin
          state_nxt = ADDR;
        end else begin
          state_nxt = RESP;
          load_nak  = 1'b1;
        end
      end
      ADDR: if (rx_fire && last_addr) state_nxt = rd_q ? REQ_DONE : DATA;
      DATA: if (rx_fire && last_data) state_nxt = REQ_DONE;
`ifdef CMD_BYTE_BRIDGE_CKSUM_EN
      CKSUM: if (rx_fire) begin
        if (b.i_rx_byte == rx_x) begin
          state_nxt = BUS;
        end else begin
          state_nxt = RESP;
          load_nak  = 1'b1;
        end
      end
`endif
      BUS: if (b.i_host_ack) begin
        state_nxt = RESP;
        load_ack  = 1'b1;
      end else if (tmo == TW'(ACK_TIMEOUT_CYCLES - 1)) begin
        state_nxt = RESP;
        load_nak  = 1'b1;
      end
      RESP: if (tx_fire && left == LW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response image: status byte at the top, shifted out MSB-first.
  always_comb begin
    rd_x = RSP_ACK;
    for (int i = 0; i < ND; i++) rd_x = rd_x ^ b.i_host_rdata[8*i +: 8];
    ack_sr = '0;
    ack_sr[RW-1 -: 8] = RSP_ACK;
    if (rd_q) begin
      ack_sr[RW-9 -: HOST_DATA_BITS] = b.i_host_rdata;
      if (CK == 1) ack_sr[7:0] = rd_x;
      ack_len = LW'(1 + ND + CK);
    end else begin
      if (CK == 1) ack_sr[RW-9 -: 8] = RSP_ACK;
      ack_len = LW'(1 + CK);
    end
    nak_sr = '0;
    nak_sr[RW-1 -: 8] = RSP_NAK;
    if (CK == 1) nak_sr[RW-9 -: 8] = RSP_NAK;
    nak_len = LW'(1 + CK);
  end

  always_ff @(posedge i_sysclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      tmo     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      run     <= 1'b0;
      rx_x    <= '0;
      sr      <= '0;
      left    <= '0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      if (rx_fire) begin
        case (state)
          IDLE: begin
            rd_q <= (b.i_rx_byte == OP_RD);
            rx_x <= b.i_rx_byte;
            cnt  <= '0;
          end
          ADDR: begin
            addr_q <= (addr_q << 8) | HOST_ADDR_BITS'(b.i_rx_byte);
            rx_x   <= rx_x ^ b.i_rx_byte;
            cnt    <= last_addr ? '0 : cnt + CW'(1);
          end
          DATA: begin
            wdata_q <= (wdata_q << 8) | HOST_DATA_BITS'(b.i_rx_byte);
            rx_x    <= rx_x ^ b.i_rx_byte;
            cnt     <= last_data ? '0 : cnt + CW'(1);
          end
          default: ;
        endcase
      end
      if (state == BUS && state_nxt == BUS) tmo <= tmo + TW'(1);
      else                                  tmo <= '0;
      if (load_ack) begin
        sr   <= ack_sr;
        left <= ack_len;
      end else if (load_nak) begin
        sr   <= nak_sr;
        left <= nak_len;
      end else if (tx_fire) begin
        sr   <= sr << 8;
        left <= left - LW'(1);
      end
    end
  end

  // run keeps o_rx_ready low while reset is held, as every output must be 0 then.
  assign b.o_rx_ready       = run && (state != BUS) && (state != RESP);
  assign b.o_tx_valid       = (state == RESP);
  assign b.o_tx_byte        = sr[RW-1 -: 8];
  assign b.o_host_sel       = (state == BUS);
  assign b.o_host_rd_wr_n   = rd_q;
  assign b.o_host_byte_addr = addr_q;
  assign b.o_host_wdata     = wdata_q;
endmodule
